// File: rtl/phys_reg_file.sv
// Physical register file with ready scoreboard, write bypass and
// optional hardwired zero register for the out-of-order core.
module phys_reg_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 64,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 2,
  parameter int ALLOC_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   rd_data,
  output logic [READ_PORTS-1:0]                   rd_ready,
  input  logic [WRITE_PORTS-1:0]                  wr_en,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  wr_addr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [ALLOC_PORTS-1:0]                  alloc_en,
  input  logic [ALLOC_PORTS-1:0][ADDR_WIDTH-1:0]  alloc_addr,
  input  logic                                    flush,
  output logic                                    wr_conflict
);

  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_d [NUM_REGS];
  logic [NUM_REGS-1:0]   ready_q;
  logic [NUM_REGS-1:0]   ready_d;
  logic                  wr_conflict_q;
  logic                  wr_conflict_d;

  logic [WRITE_PORTS-1:0] wr_hit;
  logic [ALLOC_PORTS-1:0] alloc_hit;
  logic                   conflict_now;

  // Real, writable register: in range and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = 32'(a) < NUM_REGS;
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  always_comb begin
    for (int j = 0; j < WRITE_PORTS; j++) begin
      wr_hit[j] = wr_en[j] && addr_ok(wr_addr[j]);
    end
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      alloc_hit[a] = alloc_en[a] && addr_ok(alloc_addr[a]);
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      for (int k = j + 1; k < WRITE_PORTS; k++) begin
        if (wr_hit[j] && wr_hit[k] &&
            (wr_addr[j] == wr_addr[k])) begin
          conflict_now = 1'b1;
        end
      end
    end
    wr_conflict_d = wr_conflict_q | conflict_now;
  end

  // Ascending port order lets the highest port win on collisions.
  always_comb begin
    data_d = data_q;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (wr_hit[j]) begin
        data_d[wr_addr[j]] = wr_data[j];
      end
    end
  end

  // Later assignments override earlier ones: flush > alloc > write.
  always_comb begin
    ready_d = ready_q;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (wr_hit[j]) begin
        ready_d[wr_addr[j]] = 1'b1;
      end
    end
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      if (alloc_hit[a]) begin
        ready_d[alloc_addr[a]] = 1'b0;
      end
    end
    if (flush) begin
      ready_d = '1;
    end
  end

  always_comb begin
    for (int k = 0; k < READ_PORTS; k++) begin
      rd_data[k]  = '0;
      rd_ready[k] = 1'b1;
      if (addr_ok(rd_addr[k])) begin
        rd_data[k]  = data_q[rd_addr[k]];
        rd_ready[k] = ready_q[rd_addr[k]];
        if (BYPASS != 0) begin
          for (int j = 0; j < WRITE_PORTS; j++) begin
            if (wr_hit[j] && (wr_addr[j] == rd_addr[k])) begin
              rd_data[k]  = wr_data[j];
              rd_ready[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
      end
      ready_q       <= '1;
      wr_conflict_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      ready_q       <= ready_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed scoreboard bench for phys_reg_file (bypass and
// non-bypass builds driven side by side).
module tb_phys_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0][5:0]  rd_addr;
  logic [3:0][31:0] rd_data;
  logic [3:0]       rd_ready;
  logic [1:0]       wr_en;
  logic [1:0][5:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       alloc_en;
  logic [1:0][5:0]  alloc_addr;
  logic             flush;
  logic             wr_conflict;

  logic [3:0][5:0]  nb_rd_addr;
  logic [3:0][31:0] nb_rd_data;
  logic [3:0]       nb_rd_ready;
  logic [1:0]       nb_wr_en;
  logic [1:0][5:0]  nb_wr_addr;
  logic [1:0][31:0] nb_wr_data;
  logic [1:0]       nb_alloc_en;
  logic [1:0][5:0]  nb_alloc_addr;
  logic             nb_flush;
  logic             nb_conflict;

  phys_reg_file u_dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .wr_conflict(wr_conflict)
  );

  phys_reg_file #(.BYPASS(0)) u_nb (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (nb_rd_addr),
    .rd_data    (nb_rd_data),
    .rd_ready   (nb_rd_ready),
    .wr_en      (nb_wr_en),
    .wr_addr    (nb_wr_addr),
    .wr_data    (nb_wr_data),
    .alloc_en   (nb_alloc_en),
    .alloc_addr (nb_alloc_addr),
    .flush      (nb_flush),
    .wr_conflict(nb_conflict)
  );

  // kind 0: main read port, 1: main wr_conflict, 2: no-bypass read port
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] data;
    logic        rdy;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  task automatic push(input int kind, input int idx,
                      input logic [31:0] d, input logic r,
                      input string tag);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.data = d;
    e.rdy  = r;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic rd(input int k, input int a,
                    input logic [31:0] d, input logic r,
                    input string tag);
    rd_addr[k] = 6'(a);
    push(0, k, d, r, tag);
  endtask

  task automatic nb_rd(input int a, input logic [31:0] d,
                       input string tag);
    nb_rd_addr[0] = 6'(a);
    push(2, 0, d, 1'b1, tag);
  endtask

  task automatic conf(input logic c, input string tag);
    push(1, 0, 32'(c), 1'b1, tag);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] od;
    logic        ordy;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0: begin
          od   = rd_data[e.idx];
          ordy = rd_ready[e.idx];
        end
        1: begin
          od   = 32'(wr_conflict);
          ordy = 1'b1;
        end
        default: begin
          od   = nb_rd_data[e.idx];
          ordy = nb_rd_ready[e.idx];
        end
      endcase
      total++;
      assert (od === e.data && ordy === e.rdy) passed++;
      else begin
        fails++;
        $error("FAIL %s: got data=%h rdy=%b, expected data=%h rdy=%b",
               e.tag, od, ordy, e.data, e.rdy);
      end
    end
  endtask

  task automatic quiet();
    wr_en    = '0;
    alloc_en = '0;
    flush    = 1'b0;
    nb_wr_en = '0;
  endtask

  task automatic cyc();
    check_q();
    @(posedge clk);
    #1;
    quiet();
  endtask

  initial begin
    rd_addr       = '0;
    wr_addr       = '0;
    wr_data       = '0;
    alloc_addr    = '0;
    nb_rd_addr    = '0;
    nb_wr_addr    = '0;
    nb_wr_data    = '0;
    nb_alloc_en   = '0;
    nb_alloc_addr = '0;
    nb_flush      = 1'b0;
    quiet();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 4; k++) begin
        rd(k, c * 4 + k, 32'h0, 1'b1, "reset_sweep");
      end
      conf(1'b0, "reset_conflict");
      cyc();
    end

    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd5;
    rd(0, 5, 32'h0, 1'b1, "alloc_same_cycle_ready");
    cyc();
    rd(0, 5, 32'h0, 1'b0, "alloc_next_cycle");
    cyc();
    wr_en[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 32'hDEADBEEF;
    rd(0, 5, 32'hDEADBEEF, 1'b1, "wb_bypass");
    cyc();
    rd(0, 5, 32'hDEADBEEF, 1'b1, "wb_stored");
    cyc();

    nb_wr_en[0] = 1'b1; nb_wr_addr[0] = 6'd9; nb_wr_data[0] = 32'h11;
    nb_rd(9, 32'h0, "nobyp_first");
    cyc();
    nb_wr_en[0] = 1'b1; nb_wr_addr[0] = 6'd9; nb_wr_data[0] = 32'h22;
    nb_rd(9, 32'h11, "nobyp_second");
    cyc();
    nb_rd(9, 32'h22, "nobyp_after");
    cyc();

    wr_en = 2'b11;
    wr_addr[0] = 6'd12; wr_data[0] = 32'hAAAA;
    wr_addr[1] = 6'd12; wr_data[1] = 32'h5555;
    rd(1, 12, 32'h5555, 1'b1, "conflict_bypass");
    conf(1'b0, "conflict_pre_edge");
    cyc();
    rd(1, 12, 32'h5555, 1'b1, "conflict_winner");
    conf(1'b1, "conflict_set");
    cyc();
    for (int i = 0; i < 3; i++) begin
      conf(1'b1, "conflict_sticky");
      cyc();
    end

    alloc_en = 2'b11; alloc_addr[0] = 6'd3; alloc_addr[1] = 6'd7;
    cyc();
    flush = 1'b1;
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd8;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd3; wr_data[0] = 32'h77;
    rd(0, 3, 32'h77, 1'b1, "flush_cycle_r3");
    rd(1, 7, 32'h0, 1'b0, "flush_cycle_r7");
    rd(2, 8, 32'h0, 1'b1, "flush_cycle_r8");
    cyc();
    rd(0, 3, 32'h77, 1'b1, "post_flush_r3");
    rd(1, 7, 32'h0, 1'b1, "post_flush_r7");
    rd(2, 8, 32'h0, 1'b1, "post_flush_r8");
    cyc();

    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd20;
    wr_en[1] = 1'b1; wr_addr[1] = 6'd20; wr_data[1] = 32'hCAFE;
    cyc();
    rd(0, 20, 32'hCAFE, 1'b0, "alloc_beats_write");
    cyc();

    alloc_en = 2'b11; alloc_addr[0] = 6'd21; alloc_addr[1] = 6'd21;
    cyc();
    rd(0, 21, 32'h0, 1'b0, "dup_alloc");
    cyc();

    wr_en[0] = 1'b1; wr_addr[0] = 6'd0; wr_data[0] = 32'h1234;
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd0;
    rd(0, 0, 32'h0, 1'b1, "zero_reg_bypass");
    cyc();
    rd(0, 0, 32'h0, 1'b1, "zero_reg_stored");
    cyc();

    rst = 1'b1;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd4; wr_data[0] = 32'h9;
    @(posedge clk);
    #1;
    rst = 1'b0;
    quiet();
    rd(0, 4, 32'h0, 1'b1, "rst_beats_write");
    rd(1, 12, 32'h0, 1'b1, "rst_clears_data");
    rd(2, 5, 32'h0, 1'b1, "rst_r5");
    rd(3, 20, 32'h0, 1'b1, "rst_sets_ready");
    conf(1'b0, "rst_clears_conflict");
    cyc();

    wr_en = 2'b11;
    wr_addr[0] = 6'd0; wr_data[0] = 32'h1;
    wr_addr[1] = 6'd0; wr_data[1] = 32'h2;
    cyc();
    conf(1'b0, "zero_dup_no_conflict");
    rd(0, 0, 32'h0, 1'b1, "zero_dup_data");
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/phys_reg_file.md
Name: phys_reg_file

Overview:
Parametrised multi-port physical register file for the out-of-order core.
- Replaces the single-cycle architectural RF.
- Adds a per-register ready scoreboard: bits are cleared on rename allocation, set on writeback, and all set by flush.
- Adds same-cycle write-to-read bypass, an optional hardwired zero register, and a sticky write-conflict flag.
- Sits between rename/issue (reads and allocations) and the writeback buses (writes).

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REGS, 64, number of physical registers
ADDR_WIDTH, $clog2(NUM_REGS), register index width
READ_PORTS, 4, number of combinational read ports
WRITE_PORTS, 2, number of writeback ports
ALLOC_PORTS, 2, number of rename allocation ports (clear ready)
ZERO_REG, 1, 1 = register 0 always reads 0, is always ready, and ignores writes and allocs
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
rd_addr  input  [READ_PORTS][ADDR_WIDTH]  read indices
rd_data  output  [READ_PORTS][DATA_WIDTH]  read data (combinational)
rd_ready  output  [READ_PORTS]  ready bit of the addressed register (combinational)
wr_en  input  [WRITE_PORTS]  write enables
wr_addr  input  [WRITE_PORTS][ADDR_WIDTH]  write indices
wr_data  input  [WRITE_PORTS][DATA_WIDTH]  write data
alloc_en  input  [ALLOC_PORTS]  allocation enables
alloc_addr  input  [ALLOC_PORTS][ADDR_WIDTH]  registers being allocated
flush  input  1  set every ready bit
wr_conflict  output  1  sticky flag: two enabled write ports targeted the same register in one cycle

Behaviour:
Reset
- rst sampled high at posedge: all data 0, all ready bits 1, wr_conflict 0.
- rst overrides every other input that cycle, including mid-operation writes, allocs and flush.

Writes
- Data commits at posedge when wr_en[j] is high.
- Several enabled ports with the same wr_addr: the highest port index wins, and wr_conflict is set to 1 at that edge.
- wr_conflict holds until rst.
- Writes to register 0 when ZERO_REG=1 are dropped and never count as a conflict.

Reads
- Read path is purely combinational; no clocked latency.
- When BYPASS=1 and an enabled write port targets rd_addr[k] this cycle:
  - rd_data[k] = that port's wr_data (highest enabled index wins).
  - rd_ready[k] = 1.
- Otherwise rd_data[k] and rd_ready[k] come from stored state.
- When BYPASS=0, a read returns the pre-edge value.
- ZERO_REG=1 and rd_addr=0: rd_data=0 and rd_ready=1, regardless of bypass.

Ready scoreboard, next-state priority per register, highest first:
1. rst -> 1
2. flush -> 1
3. alloc_en hit -> 0
4. wr_en hit -> 1
5. otherwise hold

Further ready rules:
- Alloc and write to the same register in one cycle: ready becomes 0, and the data is still written.
- Flush never changes data. Writes in the flush cycle still commit their data.
- Allocs in the flush cycle are ignored (ready becomes 1).
- Duplicate alloc addresses in one cycle are legal and equivalent to a single alloc.
- Allocs to register 0 are ignored when ZERO_REG=1.
- rd_ready reflects pre-edge state plus bypass only. A same-cycle alloc becomes visible on the next cycle.

Out-of-range indices cannot occur when NUM_REGS is a power of two. Otherwise:
- Writes and allocs to them are ignored.
- Reads from them return 0 and ready 1.

Test Plan:
- Reset, then read all 64 registers over 16 cycles on 4 ports -> every rd_data=0, rd_ready=1, wr_conflict=0.
- Alloc reg 5 at cycle 1 -> rd_ready for reg 5 = 0 from cycle 2. wr_en[0] reg 5 with 0xDEADBEEF at cycle 3 -> in cycle 3, rd_data=0xDEADBEEF and rd_ready=1 via bypass; from cycle 4 the same values come from storage.
- BYPASS=0 build: write 0x11 then 0x22 to reg 9 in consecutive cycles -> same-cycle reads return the prior value (0, then 0x11); the cycle after the second write reads 0x22.
- wr_en[0] and wr_en[1] both target reg 12, with data 0xAAAA and 0x5555 -> reg 12 = 0x5555 and wr_conflict=1. It stays 1 through idle cycles and clears only on rst.
- Alloc regs 3 and 7, then assert flush with alloc reg 8 and write reg 3 = 0x77 -> regs 3, 7 and 8 all read ready=1, and reg 3 = 0x77.
- ZERO_REG=1: write 0x1234 to reg 0 and alloc reg 0 -> reg 0 still reads 0 with ready 1. A duplicate write to reg 0 on both ports leaves wr_conflict=0. Asserting rst alongside a write to reg 4 = 0x9 -> reg 4 reads 0 afterwards.
